// File: rtl/fp32_to_int32.sv
// fp32_to_int32: two-stage pipelined IEEE-754 binary32 to signed int32
// converter. Rounds toward zero, saturates on overflow/infinity, returns a
// programmable value for NaN, and uses a valid/ready handshake on both sides.
module fp32_to_int32 #(
  parameter logic [31:0] NAN_VALUE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_inexact
);

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,  // zero or denormal (exp field == 0)
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  localparam logic [31:0] POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_SAT = 32'h8000_0000;

  // Stage 1 registers: decoded operand
  logic               s1_valid;
  logic               s1_sign;
  logic signed [8:0]  s1_exp;
  logic [23:0]        s1_sig;
  cls_t               s1_cls;

  // Decode of the incoming operand
  logic [7:0]         dec_exp_field;
  logic [22:0]        dec_frac;
  logic signed [8:0]  dec_exp;
  logic [23:0]        dec_sig;
  cls_t               dec_cls;

  // Conversion results from stage 1 contents
  logic [53:0]        conv_shifted;
  logic [30:0]        conv_mag;
  logic [31:0]        conv_data;
  logic               conv_invalid;
  logic               conv_inexact;

  // Stage 2 may take a new result when it is empty or being drained.
  logic               advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = rst_n && (!s1_valid || advance);

  // Split the operand into sign, unbiased exponent, significand and class
  always_comb begin
    dec_exp_field = in_data[30:23];
    dec_frac      = in_data[22:0];
    dec_exp       = $signed({1'b0, dec_exp_field}) - 9'sd127;
    dec_sig       = {(dec_exp_field != 8'd0), dec_frac};
    if (dec_exp_field == 8'd0) begin
      dec_cls = CLS_ZERO;
    end else if (dec_exp_field == 8'hFF) begin
      dec_cls = (dec_frac != 23'd0) ? CLS_NAN : CLS_INF;
    end else begin
      dec_cls = CLS_NORM;
    end
  end

  // Truncating conversion; the 54-bit product sig*2^e keeps the integer part
  // in [53:23] and every discarded fraction bit in [22:0].
  always_comb begin
    conv_data    = 32'd0;
    conv_invalid = 1'b0;
    conv_inexact = 1'b0;
    conv_shifted = {30'd0, s1_sig} << s1_exp[4:0];
    conv_mag     = conv_shifted[53:23];
    case (s1_cls)
      CLS_NAN: begin
        conv_data    = NAN_VALUE;
        conv_invalid = 1'b1;
      end
      CLS_INF: begin
        conv_data    = s1_sign ? NEG_SAT : POS_SAT;
        conv_invalid = 1'b1;
      end
      CLS_ZERO: begin
        // Denormals truncate to zero; only a true zero is exact.
        conv_inexact = (s1_sig != 24'd0);
      end
      default: begin
        if (s1_exp < 9'sd0) begin
          conv_inexact = 1'b1;
        end else if (s1_exp <= 9'sd30) begin
          conv_inexact = (conv_shifted[22:0] != 23'd0);
          conv_data    = s1_sign ? (32'd0 - {1'b0, conv_mag}) : {1'b0, conv_mag};
        end else if ((s1_exp == 9'sd31) && s1_sign && (s1_sig[22:0] == 23'd0)) begin
          // -2^31 is the one representable value with e == 31.
          conv_data = NEG_SAT;
        end else begin
          conv_data    = s1_sign ? NEG_SAT : POS_SAT;
          conv_invalid = 1'b1;
        end
      end
    endcase
  end

  // Pipeline registers: stage 1 loads on input handshake, stage 2 on advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 32'd0;
      out_invalid <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= in_data[31];
          s1_exp  <= dec_exp;
          s1_sig  <= dec_sig;
          s1_cls  <= dec_cls;
        end
      end
      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data    <= conv_data;
          out_invalid <= conv_invalid;
          out_inexact <= conv_inexact;
        end
      end
    end
  end

endmodule

// File: doc/fp32_to_int32.md
FP32_TO_INT32 -- requirements
Module: fp32_to_int32

Interface
REQ-001 SHALL have parameter NAN_VALUE, default 32'h8000_0000: result returned for NaN input.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1: in_data is valid this cycle.
REQ-005 SHALL have port in_ready  output  1: block accepts in_data this cycle.
REQ-006 SHALL have port in_data  input  32: IEEE-754 binary32 operand {sign, exp[7:0], frac[22:0]}.
REQ-007 SHALL have port out_valid  output  1: out_data and flags are valid.
REQ-008 SHALL have port out_ready  input  1: consumer accepts the result this cycle.
REQ-009 SHALL have port out_data  output  32: two's-complement signed int32 result.
REQ-010 SHALL have port out_invalid  output  1: NaN, infinity or out-of-range input.
REQ-011 SHALL have port out_inexact  output  1: nonzero fraction bits discarded.

Function
REQ-012 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-013 SHALL use a 2-stage pipeline: S1 registers sign, unbiased exponent e = exp-127 (9-bit signed), significand {1,frac} (hidden bit 0 when exp==0), and class (zero/denorm, normal, inf, NaN); S2 registers out_data and flags.
REQ-014 SHALL present a result accepted in cycle N at out_valid in cycle N+2 when out_ready has been held high.
REQ-015 SHALL sustain one result per cycle; in_ready = !s1_valid || !s2_valid || out_ready, and S1 advances into S2 under the same condition.
REQ-016 SHALL hold out_data, flags and out_valid stable while out_valid && !out_ready; no result is dropped or duplicated.
REQ-017 SHALL round toward zero (truncate).
REQ-018 NaN (exp==255, frac!=0): out_data=NAN_VALUE, invalid=1, inexact=0.
REQ-019 Infinity (exp==255, frac==0): out_data=32'h7FFF_FFFF (+) or 32'h8000_0000 (-), invalid=1, inexact=0.
REQ-020 e<0: out_data=0, invalid=0, inexact=1 unless the input is +/-0.0 (then inexact=0).
REQ-021 0<=e<=30: magnitude = significand << (e-23) for e>=23, otherwise significand >> (23-e); inexact=1 if any shifted-out bit is 1; out_data = sign ? -magnitude : magnitude; invalid=0.
REQ-022 e==31, sign=1, frac==0 (exactly -2^31): out_data=32'h8000_0000, invalid=0, inexact=0.
REQ-023 Any other e>=31: saturate as in REQ-019, invalid=1, inexact=0.
REQ-024 -0.0 SHALL yield out_data=0, not 32'h8000_0000.
REQ-025 A simultaneous output handshake and input acceptance in one cycle SHALL move both stages without a bubble.

Reset
REQ-026 When rst_n=0 at a rising clk edge, SHALL clear s1_valid, s2_valid and out_valid, and set out_data=0, out_invalid=0, out_inexact=0.
REQ-027 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after reset release.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight results; no stale result appears after release.

Verification
REQ-029 Single ops with out_ready=1: 32'h3FC0_0000 (1.5) gives 1, inexact=1; 32'hC2F6_0000 (-123.0) gives 32'hFFFF_FF85, flags 0; each result at cycle N+2.
REQ-030 Boundary cases: 32'h4EFF_FFFF gives 32'h7FFF_FF80, flags 0; 32'hCF00_0000 gives 32'h8000_0000, flags 0; 32'h4F00_0000 gives 32'h7FFF_FFFF, invalid=1.
REQ-031 Specials: 32'h7FC0_0000 gives NAN_VALUE, invalid=1; 32'hFF80_0000 gives 32'h8000_0000, invalid=1; 32'h8000_0000 (-0.0) gives 0, flags 0; 32'h0000_0001 gives 0, inexact=1.
REQ-032 Backpressure: stream 8 back-to-back inputs with out_ready low for 3 cycles mid-stream; in_ready falls once both stages are full, and all 8 results arrive in order, unmodified and without duplication.
REQ-033 Reset mid-stream: pull rst_n low for one cycle with both stages full; out_valid=0 on the next cycle, in_ready=1 after release, and no pre-reset result is emitted.
REQ-034 Random: 10^5 operands compared against a truncating reference model with random in_valid/out_ready, checking data, flags and ordering.
